// File: rtl/tawas_rcn_pkg.sv
// Shared types and constants for the tawas RCN bridge: FSM encoding, queued request
// layout, mask constants and the write-back data extractor.
package tawas_rcn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StXrd,
        StXwr,
        StWb
    } state_e;

    localparam logic [3:0]  MASK_W   = 4'b1111;
    localparam logic [3:0]  MASK_HLO = 4'b0011;
    localparam logic [3:0]  MASK_HHI = 4'b1100;
    localparam logic [31:0] TMO_DATA = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        xch;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  wbreg;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } rcn_req_t;

    localparam int unsigned REQ_W = $bits(rcn_req_t);

    // Selects the addressed lane of a read word and zero-extends it.
    function automatic logic [31:0] rcn_extract(input logic [3:0] mask, input logic [31:0] data);
        logic [31:0] res;
        case (mask)
            MASK_W:   res = data;
            MASK_HLO: res = {16'd0, data[15:0]};
            MASK_HHI: res = {16'd0, data[31:16]};
            4'b0001:  res = {24'd0, data[7:0]};
            4'b0010:  res = {24'd0, data[15:8]};
            4'b0100:  res = {24'd0, data[23:16]};
            4'b1000:  res = {24'd0, data[31:24]};
            default:  res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tawas_rcn_fifo.sv
// Synchronous request queue; a push into a full queue is dropped, pointers wrap
// modulo DEPTH (power of two).
module tawas_rcn_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/tawas_rcn_bridge.sv
// Bridges the tawas core request channel onto a simple req/ack bus: queues requests,
// runs reads, writes and locked exchanges, and writes read data back to a register.
module tawas_rcn_bridge
    import tawas_rcn_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rcn_cs,
    input  logic        rcn_xch,
    input  logic        rcn_wr,
    input  logic [31:0] rcn_addr,
    input  logic [2:0]  rcn_wbreg,
    input  logic [3:0]  rcn_mask,
    input  logic [31:0] rcn_wdata,
    output logic        rcn_full,
    output logic        bus_req,
    output logic        bus_wr,
    output logic        bus_lock,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_mask,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_en,
    output logic [2:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int unsigned CNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e       state_q, state_d;
    rcn_req_t     cur_q, cur_d;
    rcn_req_t     push_req;
    rcn_req_t     head;
    logic [31:0]  data_q, data_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic         err_q, err_d;
    logic         gap_q, gap_d;
    logic         pop;
    logic         ack;
    logic         tmo_hit;
    logic [CNT_W-1:0] fifo_count;
    logic         fifo_full;
    logic         fifo_empty;

    assign push_req = '{xch: rcn_xch, wr: rcn_wr, addr: rcn_addr, wbreg: rcn_wbreg,
                        mask: rcn_mask, wdata: rcn_wdata};

    tawas_rcn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rcn_cs),
        .pop   (pop),
        .wdata (push_req),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One slot of headroom covers a request the core already has in flight.
    assign rcn_full = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));

    // The exchange write beat idles for one cycle (gap_q) after the read beat.
    assign bus_req  = (state_q == StRd) || (state_q == StWr) || (state_q == StXrd) ||
                      ((state_q == StXwr) && !gap_q);
    assign bus_wr   = (state_q == StWr) || (state_q == StXwr);
    assign bus_lock = (state_q == StXrd) || (state_q == StXwr);
    assign bus_addr  = cur_q.addr;
    assign bus_mask  = cur_q.mask;
    assign bus_wdata = cur_q.wdata;

    assign wb_en   = (state_q == StWb);
    assign wb_reg  = cur_q.wbreg;
    assign wb_data = data_q;
    assign err     = err_q;

    assign ack     = bus_req && bus_ack;
    assign tmo_hit = bus_req && !bus_ack && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = 1'b0;

        if (rcn_cs && fifo_full) begin
            err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    if (head.xch) begin
                        state_d = StXrd;
                    end else if (head.wr) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (ack) begin
                    data_d  = rcn_extract(cur_q.mask, bus_rdata);
                    state_d = StWb;
                end
            end
            StWr: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            StXrd: begin
                if (ack) begin
                    data_d  = rcn_extract(cur_q.mask, bus_rdata);
                    state_d = StXwr;
                end
            end
            StXwr: begin
                if (ack) begin
                    state_d = StWb;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort: plain writes return quietly, anything with a read side writes back all-ones.
        if (tmo_hit) begin
            err_d = 1'b1;
            if (cur_q.wr && !cur_q.xch) begin
                state_d = StIdle;
            end else begin
                data_d  = TMO_DATA;
                state_d = StWb;
            end
        end

        gap_d = (state_q == StXrd) && (state_d == StXwr);

        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (bus_req && !bus_ack) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

    always_ff @(posedge clk) begin
        cur_q  <= cur_d;
        data_q <= data_d;
    end

endmodule
